// File: rtl/alu_operand_stage.sv
// Registered ALU operand selector with valid/ready handshakes.
// Memory-sourced operands stall in WAIT_DATA until mem_valid delivers the data word.
module alu_operand_stage #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IMM_W    = 4,
    parameter int unsigned IMM_SEXT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [WIDTH-1:0] in_sr,
    input  logic [WIDTH-1:0] in_dr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_offset,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_sr,
    output logic [WIDTH-1:0] alu_dr,
    output logic [2:0]       out_sel
);

    localparam int unsigned SEL_W = 3;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_pend_sel;
    logic [WIDTH-1:0]   r_pend_dr;
    logic [WIDTH-1:0]   r_data_hold;
    logic               r_data_ok;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_alu_sr;
    logic [WIDTH-1:0]   r_alu_dr;
    logic [SEL_W-1:0]   r_out_sel;

    logic [WIDTH-1:0]   w_immx;
    logic               w_out_free;
    logic               w_accept;
    logic               w_is_data;
    logic               w_load_now;
    logic               w_go_wait;
    logic               w_pend_fire;
    logic               w_load;
    logic [WIDTH-1:0]   w_pend_data;
    logic [WIDTH-1:0]   w_nxt_sr;
    logic [WIDTH-1:0]   w_nxt_dr;
    logic [SEL_W-1:0]   w_nxt_sel;

    // (sr, dr) operand pair for a select code
    function automatic logic [2*WIDTH-1:0] f_pair(
        input logic [SEL_W-1:0] sel,
        input logic [WIDTH-1:0] sr,
        input logic [WIDTH-1:0] dr,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] off,
        input logic [WIDTH-1:0] immx,
        input logic [WIDTH-1:0] data
    );
        logic [WIDTH-1:0] zero;
        zero = '0;
        case (sel)
            3'b000:  f_pair = {sr,   dr};
            3'b001:  f_pair = {sr,   zero};
            3'b010:  f_pair = {zero, dr};
            3'b011:  f_pair = {off,  pc};
            3'b100:  f_pair = {zero, pc};
            3'b101:  f_pair = {zero, data};
            3'b110:  f_pair = {immx, dr};
            default: f_pair = {data, dr};
        endcase
    endfunction

    generate
        if (IMM_SEXT != 0) begin : g_sext
            assign w_immx = {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        end else begin : g_zext
            assign w_immx = WIDTH'(in_imm);
        end
    endgenerate

    assign w_out_free  = !r_out_valid || out_ready;
    assign in_ready    = (r_state == S_IDLE) && w_out_free && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_is_data   = in_sel[2] && in_sel[0];
    assign w_pend_data = mem_valid ? mem_data : r_data_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_go_wait)   w_state_nxt = S_WAIT;
                S_WAIT:  if (w_pend_fire) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Load decisions and the operand pair to capture
    always_comb begin
        w_load_now  = w_accept && (!w_is_data || mem_valid);
        w_go_wait   = w_accept && w_is_data && !mem_valid;
        w_pend_fire = !flush && (r_state == S_WAIT) && (r_data_ok || mem_valid) && w_out_free;
        w_load      = w_load_now || w_pend_fire;
        w_nxt_sel   = in_sel;
        {w_nxt_sr, w_nxt_dr} = f_pair(in_sel, in_sr, in_dr, in_pc, in_offset, w_immx, mem_data);
        if (w_pend_fire) begin
            w_nxt_sel = r_pend_sel;
            {w_nxt_sr, w_nxt_dr} = f_pair(r_pend_sel, '0, r_pend_dr, '0, '0, '0, w_pend_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_sel  <= '0;
            r_pend_dr   <= '0;
            r_data_hold <= '0;
            r_data_ok   <= 1'b0;
        end else begin
            if (w_go_wait) begin
                r_pend_sel <= in_sel;
                r_pend_dr  <= in_dr;
            end
            if (flush) begin
                r_data_ok <= 1'b0;
            end else if (r_state == S_WAIT) begin
                if (w_pend_fire) begin
                    r_data_ok <= 1'b0;
                end else if (mem_valid) begin
                    r_data_ok   <= 1'b1;
                    r_data_hold <= mem_data;
                end
            end
        end
    end

    // Output register: flush drops, load refills, consume drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_sr    <= '0;
            r_alu_dr    <= '0;
            r_out_sel   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_alu_sr    <= w_nxt_sr;
            r_alu_dr    <= w_nxt_dr;
            r_out_sel   <= w_nxt_sel;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign alu_sr    = r_alu_sr;
    assign alu_dr    = r_alu_dr;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: zero- and sign-extending instances share stimulus and
// are compared every cycle against a transaction-level model, plus literal spot checks.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic [3:0]  in_imm;
    logic [15:0] in_sr, in_dr, in_pc, in_offset;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        out_ready;

    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [15:0] alu_sr0, alu_sr1, alu_dr0, alu_dr1;
    logic [2:0]  out_sel0, out_sel1;

    int n_checks = 0;
    int n_errors = 0;

    // model state: output entry, outstanding memory request, captured data word
    bit          m_valid, m_wait, m_ok;
    logic [15:0] m_sr [2];
    logic [15:0] m_dr, m_hold, p_dr;
    logic [2:0]  m_sel, p_sel;

    alu_operand_stage #(.WIDTH(16), .IMM_W(4), .IMM_SEXT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sel(in_sel), .in_imm(in_imm), .in_sr(in_sr), .in_dr(in_dr), .in_pc(in_pc),
        .in_offset(in_offset), .mem_valid(mem_valid), .mem_data(mem_data),
        .out_valid(out_valid0), .out_ready(out_ready), .alu_sr(alu_sr0), .alu_dr(alu_dr0),
        .out_sel(out_sel0));

    alu_operand_stage #(.WIDTH(16), .IMM_W(4), .IMM_SEXT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sel(in_sel), .in_imm(in_imm), .in_sr(in_sr), .in_dr(in_dr), .in_pc(in_pc),
        .in_offset(in_offset), .mem_valid(mem_valid), .mem_data(mem_data),
        .out_valid(out_valid1), .out_ready(out_ready), .alu_sr(alu_sr1), .alu_dr(alu_dr1),
        .out_sel(out_sel1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // operand table written directly from the select-code list
    task automatic pick(input logic [2:0] s, input logic [15:0] sr, input logic [15:0] dr,
                        input logic [15:0] pc, input logic [15:0] off, input logic [15:0] imx,
                        input logic [15:0] data, output logic [15:0] osr, output logic [15:0] odr);
        case (s)
            3'd0: begin osr = sr;    odr = dr;    end
            3'd1: begin osr = sr;    odr = 16'h0; end
            3'd2: begin osr = 16'h0; odr = dr;    end
            3'd3: begin osr = off;   odr = pc;    end
            3'd4: begin osr = 16'h0; odr = pc;    end
            3'd5: begin osr = 16'h0; odr = data;  end
            3'd6: begin osr = imx;   odr = dr;    end
            default: begin osr = data; odr = dr;  end
        endcase
    endtask

    task automatic model_reset();
        m_valid = 0; m_wait = 0; m_ok = 0;
        m_sr[0] = 16'h0; m_sr[1] = 16'h0; m_dr = 16'h0; m_sel = 3'd0;
        p_sel = 3'd0; p_dr = 16'h0; m_hold = 16'h0;
    endtask

    task automatic model_step();
        bit          free, rdy, acc, is_data, nv;
        logic [15:0] imx [2];
        logic [15:0] data;
        free    = !m_valid || out_ready;
        rdy     = !m_wait && free && !flush;
        acc     = in_valid && rdy;
        is_data = (in_sel == 3'd5) || (in_sel == 3'd7);
        imx[0]  = {12'h000, in_imm};
        imx[1]  = 16'($signed(in_imm));
        if (flush) begin
            m_valid = 0; m_wait = 0; m_ok = 0;
        end else begin
            nv = m_valid && !out_ready;
            if (!m_wait) begin
                if (acc && (!is_data || mem_valid)) begin
                    for (int k = 0; k < 2; k++)
                        pick(in_sel, in_sr, in_dr, in_pc, in_offset, imx[k], mem_data, m_sr[k], m_dr);
                    m_sel = in_sel;
                    nv = 1;
                end else if (acc) begin
                    m_wait = 1; p_sel = in_sel; p_dr = in_dr;
                end
            end else begin
                data = mem_valid ? mem_data : m_hold;
                if ((m_ok || mem_valid) && free) begin
                    for (int k = 0; k < 2; k++)
                        pick(p_sel, 16'h0, p_dr, 16'h0, 16'h0, 16'h0, data, m_sr[k], m_dr);
                    m_sel = p_sel;
                    m_ok = 0; m_wait = 0; nv = 1;
                end else if (mem_valid) begin
                    m_hold = mem_data; m_ok = 1;
                end
            end
            m_valid = nv;
        end
    endtask

    task automatic compare_outputs();
        chk("out_valid0", 32'(out_valid0), 32'(m_valid));
        chk("out_valid1", 32'(out_valid1), 32'(m_valid));
        if (m_valid) begin
            chk("alu_sr0", 32'(alu_sr0), 32'(m_sr[0]));
            chk("alu_sr1", 32'(alu_sr1), 32'(m_sr[1]));
            chk("alu_dr0", 32'(alu_dr0), 32'(m_dr));
            chk("alu_dr1", 32'(alu_dr1), 32'(m_dr));
            chk("out_sel0", 32'(out_sel0), 32'(m_sel));
            chk("out_sel1", 32'(out_sel1), 32'(m_sel));
        end
    endtask

    // one clock: check registered outputs, drive inputs, check in_ready, advance model
    task automatic step(input logic v, input logic [2:0] s, input logic [3:0] imm,
                        input logic [15:0] sr, input logic [15:0] dr, input logic [15:0] pc,
                        input logic [15:0] off, input logic mv, input logic [15:0] md,
                        input logic ord, input logic fl);
        @(negedge clk);
        compare_outputs();
        in_valid = v; in_sel = s; in_imm = imm; in_sr = sr; in_dr = dr; in_pc = pc;
        in_offset = off; mem_valid = mv; mem_data = md; out_ready = ord; flush = fl;
        #1;
        chk("in_ready0", 32'(in_ready0), 32'(!m_wait && (!m_valid || out_ready) && !flush));
        chk("in_ready1", 32'(in_ready1), 32'(!m_wait && (!m_valid || out_ready) && !flush));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_sel = 3'd0; in_imm = 4'h0; in_sr = 16'h0; in_dr = 16'h0;
        in_pc = 16'h0; in_offset = 16'h0; mem_valid = 0; mem_data = 16'h0;
        out_ready = 1; flush = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12 rst_n = 1;
        #1;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_alu_sr", 32'(alu_sr0), 32'd0);
        chk("rst_alu_dr", 32'(alu_dr1), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);

        // back-to-back loads
        step(1, 3'd0, 4'h0, 16'h1234, 16'hABCD, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        chk("t2_valid", 32'(out_valid0), 32'd1);
        chk("t2_sr", 32'(alu_sr0), 32'h1234);
        chk("t2_dr", 32'(alu_dr0), 32'hABCD);
        step(1, 3'd3, 4'h0, 16'h0, 16'h0, 16'h0200, 16'h0010, 0, 16'h0, 1, 0);
        chk("t2b_sr", 32'(alu_sr0), 32'h0010);
        chk("t2b_dr", 32'(alu_dr0), 32'h0200);

        // immediate extension
        step(1, 3'd6, 4'hA, 16'h0, 16'h5555, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        chk("t3_zext", 32'(alu_sr0), 32'h000A);
        chk("t3_sext", 32'(alu_sr1), 32'hFFFA);
        chk("t3_dr", 32'(alu_dr1), 32'h5555);

        // memory-sourced operand with a late pulse
        step(1, 3'd7, 4'h0, 16'h0, 16'h0005, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        chk("t4_wait_ready", 32'(in_ready0), 32'd0);
        step(1, 3'd0, 4'h0, 16'h9999, 16'h9999, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        step(0, 3'd0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        chk("t4_still_wait", 32'(out_valid0), 32'd0);
        step(0, 3'd0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h00FF, 1, 0);
        chk("t4_valid", 32'(out_valid0), 32'd1);
        chk("t4_sr", 32'(alu_sr0), 32'h00FF);
        chk("t4_dr", 32'(alu_dr0), 32'h0005);
        chk("t4_sel", 32'(out_sel0), 32'd7);

        // held entry under backpressure, then drain and reload on one edge
        step(1, 3'd1, 4'h0, 16'hBEEF, 16'h0001, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 3'd2, 4'h0, 16'h0, 16'hCAFE, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        chk("t5_hold_sr", 32'(alu_sr0), 32'hBEEF);
        chk("t5_hold_sel", 32'(out_sel0), 32'd1);
        step(1, 3'd2, 4'h0, 16'h0, 16'hCAFE, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        chk("t5_reload_valid", 32'(out_valid0), 32'd1);
        chk("t5_reload_dr", 32'(alu_dr0), 32'hCAFE);

        // flush while waiting; a later pulse must be ignored
        step(1, 3'd5, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        step(0, 3'd0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 1, 1);
        chk("t6_flush_valid", 32'(out_valid0), 32'd0);
        step(0, 3'd0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h7777, 1, 0);
        chk("t6_ignored", 32'(out_valid0), 32'd0);
        chk("t6_ready", 32'(in_ready0), 32'd1);

        // asynchronous reset while a memory operand is outstanding
        step(1, 3'd0, 4'h0, 16'h4321, 16'h8765, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        step(1, 3'd7, 4'h0, 16'h0, 16'h0042, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        idle_inputs();
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid1), 32'd0);
        chk("mid_rst_sr", 32'(alu_sr1), 32'd0);
        chk("mid_rst_sel", 32'(out_sel0), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("mid_rst_ready", 32'(in_ready1), 32'd1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 4'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 3), 16'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        @(negedge clk);
        compare_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
